// File: rtl/mem_access_unit.sv
// mem_access_unit: single-port load/store engine for a 2^M x 32-bit memory.
// The byte at mem_addr occupies bits 31:24 of the data lanes (big-endian).
// Each request walks IDLE -> ACCESS -> LATCH -> RESP. A rejected request
// goes straight from IDLE to RESP, and the memory is never touched.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, half and word
// accesses that are not naturally aligned are rejected. When it is undefined,
// those accesses go to the exact byte address.
module mem_access_unit #(
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [M+1:0] req_addr,
    input  logic [31:0]  req_wdata,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [31:0]  resp_rdata,
    output logic         resp_err,
    output logic [M+1:0] mem_addr,
    output logic [31:0]  mem_mask,
    output logic [31:0]  mem_w,
    input  logic [31:0]  mem_v
);

    // Highest byte address at which a full word still fits in memory.
    localparam logic [M+1:0] MAX_ADDR = {{M{1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        LATCH  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t        state_q;
    logic          req_ready_q;
    logic          we_q;
    logic [1:0]    size_q;
    logic          unsigned_q;
    logic [M+1:0]  addr_q;
    logic          resp_valid_q;
    logic          resp_err_q;
    logic [31:0]   resp_rdata_q;
    logic [31:0]   mem_mask_q;
    logic [31:0]   mem_w_q;

    logic          req_err_d;
    logic [31:0]   store_w_d;
    logic [31:0]   store_mask_d;
    logic [31:0]   load_data_d;

    // Decide whether the incoming request must be rejected rather than performed.
    always_comb begin
        req_err_d = (req_size == 2'd3) || (req_addr > MAX_ADDR);
`ifdef MISALIGN_TRAP_EN
        if ((req_size == 2'd1) && req_addr[0]) begin
            req_err_d = 1'b1;
        end
        if ((req_size == 2'd2) && (req_addr[1:0] != 2'b00)) begin
            req_err_d = 1'b1;
        end
`else
        req_err_d = req_err_d;
`endif
    end

    // Move right-aligned store data into the top lanes and build the write mask.
    always_comb begin
        store_w_d    = 32'h0;
        store_mask_d = 32'h0;
        case (req_size)
            2'd0: begin
                store_w_d    = {req_wdata[7:0], 24'h0};
                store_mask_d = 32'hFF00_0000;
            end
            2'd1: begin
                store_w_d    = {req_wdata[15:0], 16'h0};
                store_mask_d = 32'hFFFF_0000;
            end
            2'd2: begin
                store_w_d    = req_wdata;
                store_mask_d = 32'hFFFF_FFFF;
            end
            default: begin
                store_w_d    = 32'h0;
                store_mask_d = 32'h0;
            end
        endcase
    end

    // Take the addressed bytes from the top lanes of the read data and extend them to 32 bits.
    always_comb begin
        load_data_d = 32'h0;
        case (size_q)
            2'd0: load_data_d = unsigned_q ? {24'h0, mem_v[31:24]}
                                           : {{24{mem_v[31]}}, mem_v[31:24]};
            2'd1: load_data_d = unsigned_q ? {16'h0, mem_v[31:16]}
                                           : {{16{mem_v[31]}}, mem_v[31:16]};
            2'd2: load_data_d = mem_v;
            default: load_data_d = 32'h0;
        endcase
    end

    // Request FSM. Every output is registered here so the memory side sees glitch-free signals.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            addr_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_mask_q   <= 32'h0;
            mem_w_q      <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q        <= req_we;
                        size_q      <= req_size;
                        unsigned_q  <= req_unsigned;
                        addr_q      <= req_addr;
                        req_ready_q <= 1'b0;
                        if (req_err_d) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'h0;
                        end else begin
                            state_q <= ACCESS;
                            if (req_we) begin
                                mem_mask_q <= store_mask_d;
                                mem_w_q    <= store_w_d;
                            end
                        end
                    end
                end
                ACCESS: begin
                    mem_mask_q <= 32'h0;
                    mem_w_q    <= 32'h0;
                    state_q    <= LATCH;
                end
                LATCH: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? 32'h0 : load_data_d;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= 32'h0;
                        req_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_addr   = addr_q;
    assign mem_mask   = mem_mask_q;
    assign mem_w      = mem_w_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard testbench for mem_access_unit (M = 10).
// A bit-masked byte memory stands in for the real memory. A shadow byte
// image predicts the expected results, independently of the memory model.
// The expected outcome follows MISALIGN_TRAP_EN when that macro is defined.
module tb_mem_access_unit;

    localparam int M         = 10;
    localparam int ADDR_W    = M + 2;
    localparam int MEM_BYTES = 4 * (2 ** M);

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_mask;
    logic [31:0]       mem_w;
    logic [31:0]       mem_v;

    logic [7:0] physMem   [0:MEM_BYTES-1];
    logic [7:0] shadowMem [0:MEM_BYTES-1];
    exp_t       expQ[$];
    int         checkCount;
    int         errorCount;

    mem_access_unit #(.M(M)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_mask     (mem_mask),
        .mem_w        (mem_w),
        .mem_v        (mem_v)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: apply the bit-masked write at mem_addr, then read back the four bytes there.
    always @(posedge clk) begin
        int a;
        int idx;
        a = int'(mem_addr);
        for (int b = 0; b < 4; b++) begin
            idx = (a + b) % MEM_BYTES;
            physMem[idx] = (physMem[idx] & ~mem_mask[31-8*b -: 8]) |
                           (mem_w[31-8*b -: 8] & mem_mask[31-8*b -: 8]);
        end
        mem_v <= {physMem[a % MEM_BYTES], physMem[(a + 1) % MEM_BYTES],
                  physMem[(a + 2) % MEM_BYTES], physMem[(a + 3) % MEM_BYTES]};
    end

    // Single comparison point: count it, and report it when it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] required);
        checkCount++;
        if (observed !== required) begin
            errorCount++;
            $display("[TB] FAIL %s: observed %h, required %h", tag, observed, required);
        end
    endtask

    function automatic logic isErr(input logic [1:0] size, input int addr);
        logic e;
        e = (size == 2'd3) || (addr > MEM_BYTES - 4);
`ifdef MISALIGN_TRAP_EN
        if (size == 2'd1 && (addr % 2) != 0) e = 1'b1;
        if (size == 2'd2 && (addr % 4) != 0) e = 1'b1;
`endif
        return e;
    endfunction

    function automatic logic [31:0] shadowWord(input int a);
        return {shadowMem[a % MEM_BYTES], shadowMem[(a + 1) % MEM_BYTES],
                shadowMem[(a + 2) % MEM_BYTES], shadowMem[(a + 3) % MEM_BYTES]};
    endfunction

    function automatic logic [31:0] physWord(input int a);
        return {physMem[a % MEM_BYTES], physMem[(a + 1) % MEM_BYTES],
                physMem[(a + 2) % MEM_BYTES], physMem[(a + 3) % MEM_BYTES]};
    endfunction

    // Issue one request and predict its result, then follow it to its response and complete the handshake.
    task automatic applyStimulus(input logic we, input logic [1:0] size, input logic uns,
                                 input int addr, input logic [31:0] wdata, input int holdCycles);
        exp_t        e;
        exp_t        got;
        logic        err;
        logic [31:0] word;
        logic [31:0] expMask;
        logic [31:0] expW;
        logic [31:0] maskOr;
        int          nb;
        int          lat;
        err     = isErr(size, addr);
        word    = shadowWord(addr);
        e.err   = err;
        e.rdata = 32'h0;
        expMask = 32'h0;
        expW    = 32'h0;
        nb      = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (!err && !we) begin
            if (size == 2'd0)      e.rdata = uns ? {24'h0, word[31:24]} : {{24{word[31]}}, word[31:24]};
            else if (size == 2'd1) e.rdata = uns ? {16'h0, word[31:16]} : {{16{word[31]}}, word[31:16]};
            else                   e.rdata = word;
        end
        if (!err && we) begin
            for (int b = 0; b < nb; b++) begin
                shadowMem[(addr + b) % MEM_BYTES] = wdata[8*(nb-1-b) +: 8];
                expMask[31-8*b -: 8] = 8'hFF;
                expW[31-8*b -: 8]    = wdata[8*(nb-1-b) +: 8];
            end
        end
        expQ.push_back(e);

        @(negedge clk);
        checkOutput("readyBeforeReq", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = ADDR_W'(addr);
        req_wdata    = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        lat       = 1;
        maskOr    = 32'h0;
        if (!err && we) begin
            checkOutput("storeMask", mem_mask, expMask);
            checkOutput("storeData", mem_w, expW);
        end else begin
            maskOr |= mem_mask;
        end
        while (!resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            maskOr |= mem_mask;
        end
        got = expQ.pop_front();
        if (!resp_valid) begin
            checkOutput("respTimeout", 32'(resp_valid), 32'd1);
            return;
        end
        checkOutput("latency", 32'(lat), err ? 32'd1 : 32'd3);
        checkOutput("maskQuiet", maskOr, 32'h0);
        checkOutput("rdata", resp_rdata, got.rdata);
        checkOutput("err", 32'(resp_err), 32'(got.err));
        checkOutput("memAddr", 32'(mem_addr), 32'(addr));
        for (int h = 0; h < holdCycles; h++) begin
            @(negedge clk);
            checkOutput("holdValid", 32'(resp_valid), 32'd1);
            checkOutput("holdRdata", resp_rdata, got.rdata);
            checkOutput("holdErr", 32'(resp_err), 32'(got.err));
            checkOutput("holdReady", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checkOutput("respDone", 32'(resp_valid), 32'd0);
        checkOutput("readyAfterResp", 32'(req_ready), 32'd1);
    endtask

    // Start a word store, then pulse reset while the store is in ACCESS. The store must vanish without a trace.
    task automatic applyResetPulse(input int addr, input logic [31:0] wdata);
        logic seen;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = ADDR_W'(addr);
        req_wdata    = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("preResetMask", mem_mask, 32'hFFFF_FFFF);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstMaskNow", mem_mask, 32'h0);
        checkOutput("rstWNow", mem_w, 32'h0);
        checkOutput("rstReadyNow", 32'(req_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= resp_valid;
        end
        checkOutput("noRespAfterRst", 32'(seen), 32'd0);
        checkOutput("readyAfterRst", 32'(req_ready), 32'd1);
        checkOutput("rstNoWrite", physWord(addr), shadowWord(addr));
    endtask

    // Watchdog so the run always ends, even if the design wedges.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed cases, boundary cases, reset abort, random traffic and a final memory audit.
    initial begin
        int bad;
        checkCount   = 0;
        errorCount   = 0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;
        mem_v        = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            physMem[i]   = 8'h00;
            shadowMem[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        checkOutput("rstReady", 32'(req_ready), 32'd1);
        checkOutput("rstValid", 32'(resp_valid), 32'd0);
        checkOutput("rstErr", 32'(resp_err), 32'd0);
        checkOutput("rstRdata", resp_rdata, 32'h0);
        checkOutput("rstAddr", 32'(mem_addr), 32'h0);
        checkOutput("rstMask", mem_mask, 32'h0);
        checkOutput("rstW", mem_w, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] word store/load");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        $display("[TB] byte store and byte loads");
        applyStimulus(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AB, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 0);
        applyStimulus(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0);
        $display("[TB] half load with back-pressure");
        applyStimulus(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8001, 0);
        applyStimulus(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0);
        $display("[TB] error and boundary requests");
        applyStimulus(1'b0, 2'd2, 1'b0, 32'hFFD, 32'h0, 0);
        applyStimulus(1'b0, 2'd0, 1'b0, 32'hFFD, 32'h0, 0);
        applyStimulus(1'b1, 2'd3, 1'b0, 32'h20, 32'h5555_AAAA, 2);
        checkOutput("reservedNoWrite", physWord(32'h20), 32'h0);
        applyStimulus(1'b1, 2'd2, 1'b0, 32'hFFC, 32'h0BAD_F00D, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'hFFC, 32'h0, 0);
        $display("[TB] misaligned word store");
        applyStimulus(1'b1, 2'd2, 1'b0, 32'h13, 32'hDEAD_BEEF, 0);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 0);
        applyStimulus(1'b0, 2'd1, 1'b1, 32'h15, 32'h0, 0);
        for (int i = 32'h10; i < 32'h18; i++) begin
            checkOutput("misalignByte", 32'(physMem[i]), 32'(shadowMem[i]));
        end
        $display("[TB] reset during store access");
        applyResetPulse(32'h40, 32'hCAFE_F00D);
        applyStimulus(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0);
        $display("[TB] random traffic");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                          1'($urandom_range(0, 1)), int'($urandom_range(32'h100, 32'h10F)),
                          $urandom, int'($urandom_range(0, 2)));
        end
        bad = 0;
        for (int i = 0; i < MEM_BYTES; i++) begin
            if (physMem[i] !== shadowMem[i]) bad++;
        end
        checkOutput("memImage", 32'(bad), 32'd0);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter M, default 10, meaning the memory holds 2^M 32-bit words (4*2^M bytes).
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit accepts a request.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  0=byte, 1=half, 2=word, 3=reserved.
REQ-008 SHALL have port req_unsigned  input  1  1=zero-extend load data, 0=sign-extend.
REQ-009 SHALL have port req_addr  input  M+2  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer takes the response.
REQ-013 SHALL have port resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port resp_err  output  1  request rejected; no memory write took place.
REQ-015 SHALL have port mem_addr  output  M+2  memory byte address.
REQ-016 SHALL have port mem_mask  output  32  memory write mask; a 1 bit overwrites that bit.
REQ-017 SHALL have port mem_w  output  32  memory write data.
REQ-018 SHALL have port mem_v  input  32  memory read data, updated at each clk edge from mem_addr after any write.

Function
REQ-019 SHALL implement states IDLE, ACCESS, LATCH and RESP; req_ready=1 only in IDLE.
REQ-020 SHALL accept a request on an edge in IDLE with req_valid=1, registering all req_* fields.
REQ-021 SHALL treat a request as erroneous when req_size=3, or when req_addr > 4*2^M-4.
REQ-022 SHALL move IDLE->RESP on acceptance of an erroneous request, with resp_err=1 and resp_rdata=0, and SHALL NOT drive a nonzero mem_mask.
REQ-023 SHALL move IDLE->ACCESS->LATCH->RESP for a valid request, so resp_valid rises 3 edges after acceptance.
REQ-024 SHALL drive mem_addr = the registered address in ACCESS, LATCH and RESP.
REQ-025 SHALL use big-endian byte lanes: the byte at mem_addr maps to bits 31:24 of mem_w/mem_v.
REQ-026 SHALL drive a store in ACCESS as follows: byte: mem_w={wdata[7:0],24'h0}, mask FF000000; half: {wdata[15:0],16'h0}, mask FFFF0000; word: wdata, mask FFFFFFFF.
REQ-027 SHALL hold mem_mask=0 in every state except ACCESS of a store, so each store writes exactly once.
REQ-028 SHALL capture load data from mem_v at the LATCH->RESP edge: byte=mem_v[31:24], half=mem_v[31:16], word=mem_v, extended per req_unsigned.
REQ-029 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until an edge with resp_ready=1, then go to IDLE.
REQ-030 SHALL NOT accept a new request in the cycle a response completes; acceptance resumes on the next IDLE edge.

Reset
REQ-031 SHALL, while rst_n=0 and independently of clk, force state IDLE and req_ready=1, and force resp_valid, resp_err, resp_rdata, mem_addr, mem_mask and mem_w to 0.
REQ-032 SHALL, on reset asserted during ACCESS, drop mem_mask to 0 immediately, discard the request and return no response.

Configuration
REQ-033 SHALL, with MISALIGN_TRAP_EN defined, also treat as erroneous a half access with req_addr[0]=1 and a word access with req_addr[1:0]!=0.
REQ-034 SHALL, without MISALIGN_TRAP_EN, perform misaligned accesses at the exact byte address, subject only to REQ-021.

Verification
REQ-035 SHALL cover: word store 0x11223344 @0x10, then word load @0x10 -> resp_rdata=0x11223344, resp_err=0, resp_valid 3 edges after acceptance.
REQ-036 SHALL cover: byte store 0xAB @0x11 over 0x11223344, then word load @0x10 -> 0x11AB3344; signed byte load @0x11 -> 0xFFFFFFAB; unsigned -> 0x000000AB.
REQ-037 SHALL cover: half load @0x12, signed, with data 0x8001 -> 0xFFFF8001; resp_ready held 0 for 5 cycles -> response held constant and req_ready=0.
REQ-038 SHALL cover: with M=10, word load @0xFFD -> resp_err=1, rdata=0, 1-edge latency; req_size=3 store -> resp_err=1 and mem_mask never nonzero.
REQ-039 SHALL cover: word store @0x13 -> with MISALIGN_TRAP_EN, resp_err=1 and memory unchanged; without it, bytes 0x13..0x16 are written.
REQ-040 SHALL cover: rst_n pulsed low during ACCESS of a store -> mem_mask=0 immediately, no response, req_ready=1 after reset releases.
